subword_store_unit: RTL

//  Narrowing counterpart of the immediate/data extenders: turns sb/sh/sw store

---
 rtl/subword_store_unit_if.sv | 28 ++
 rtl/subword_store_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/subword_store_unit_if.sv
// Store request / dmem bus bundle for subword_store_unit.
// The master side is the environment: the datapath issuing the store and the
// data memory answering it. The slave side is the store unit itself.
interface subword_store_unit_if;
   logic        req;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_store;
   logic [31:0] mem_load;
   logic        mem_ready;

   modport master (
      output req, size, addr, wdata, mem_load, mem_ready,
      input  busy, done, err, mem_ren, mem_wen, mem_addr, mem_store
   );

   modport slave (
      input  req, size, addr, wdata, mem_load, mem_ready,
      output busy, done, err, mem_ren, mem_wen, mem_addr, mem_store
   );
endinterface

// File: rtl/subword_store_unit.sv
// Turns sb/sh/sw store requests into word-only dmem transactions.
// Word stores write directly; byte/halfword stores read the aligned word,
// merge the new lane into it and write the word back.
module subword_store_unit #(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int WAIT_LIMIT = 0
) (
   input logic                 CLK,
   input logic                 nRST,
   subword_store_unit_if.slave bus
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

   localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

   state_t            state, state_next;
   logic [1:0]        size_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       store_q;
   logic [CNT_W-1:0]  cnt;
   logic              bad_req;
   logic              timed_out;
   logic [31:0]       mask;
   logic [31:0]       lane_data;
   logic [31:0]       merged;
   logic              busy, done, err, mem_ren, mem_wen;

   // Byte-enable style mask of the lane being replaced inside the aligned word.
   function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] m;
      if (sz == 2'b10) begin
         if (BIG_ENDIAN) m = 32'hFF00_0000 >> {off, 3'b000};
         else            m = 32'h0000_00FF << {off, 3'b000};
      end else begin
         if (BIG_ENDIAN) m = off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
         else            m = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      return m;
   endfunction

   assign mask      = lane_mask(size_q, addr_q[1:0]);
   assign lane_data = (size_q == 2'b10) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
   assign merged    = (bus.mem_load & ~mask) | (lane_data & mask);
   assign timed_out = (WAIT_LIMIT > 0) && (cnt == CNT_LAST);

   // Classify the incoming request: misaligned or reserved size is an error.
   always_comb begin
      bad_req = 1'b0;
      case (bus.size)
         2'b00:   bad_req = (bus.addr[1:0] != 2'b00);
         2'b01:   bad_req = bus.addr[0];
         2'b10:   bad_req = 1'b0;
         default: bad_req = 1'b1;
      endcase
   end

   // State register; reset abandons any access in flight.
   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and control outputs; enables are decoded from state so
   // read and write can never overlap.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.req) begin
               if (bad_req)                state_next = ERR;
               else if (bus.size == 2'b00) state_next = WRITE;
               else                        state_next = READ;
            end
         end
         READ: begin
            mem_ren = 1'b1;
            if (bus.mem_ready)  state_next = WRITE;
            else if (timed_out) state_next = ERR;
         end
         WRITE: begin
            mem_wen = 1'b1;
            if (bus.mem_ready)  state_next = DONE;
            else if (timed_out) state_next = ERR;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         ERR: begin
            err        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, merged-word latch and per-access wait counter.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         store_q <= 32'h0;
         cnt     <= '0;
      end else begin
         if (state == IDLE && bus.req) begin
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
         end
         if (state == READ && bus.mem_ready) store_q <= merged;
         if (state_next != state) begin
            cnt <= '0;
         end else if ((WAIT_LIMIT > 0) && (state == READ || state == WRITE) && !bus.mem_ready) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;
   assign bus.mem_ren   = mem_ren;
   assign bus.mem_wen   = mem_wen;
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_store = (size_q == 2'b00) ? wdata_q : store_q;

endmodule
